// File: rtl/jogador_automatico.sv
// -----------------------------------------------------------------------------
// jogador_automatico
//
// Automatic player for the circuito_exp5 sequence game. It sits on the
// player's side of the game interface, starts a game and then plays rounds
// 1..NUM_RODADAS. Round k replays the first k entries of a fixed 16-entry
// jogadas ROM on `chaves`. Each key is held for HOLD_CYCLES and followed by
// GAP_CYCLES of silence. ROUND_WAIT idle cycles precede every round. A
// deliberate wrong key can be injected in a chosen round. The game's
// pronto/acertou/errou are watched to report the outcome.
//
// Optional feature (macro JOGADOR_REINICIO_EN):
//   defined   - FIM restarts by itself after ROUND_WAIT cycles. It replays
//               with the same latched erro_rodada.
//   undefined - FIM waits for comecar.
//
// Ports:
//   clock         in   system clock
//   reset         in   asynchronous, active-high reset
//   comecar       in   start request, accepted only in OCIOSO or FIM
//   erro_rodada   in   [4:0] round (1..16) that gets a wrong key; 0 = never
//   pronto        in   game finished
//   acertou       in   game won
//   errou         in   game lost
//   iniciar       out  one-cycle start pulse to the game
//   chaves        out  [3:0] one-hot key drive, 0 when idle
//   rodada_atual  out  [3:0] current round, 0-based
//   jogada_atual  out  [3:0] current jogada within the round
//   ocupado       out  high except in OCIOSO and FIM
//   fim_ok        out  game reported a win
//   fim_erro      out  game reported a loss, or the watchdog expired
//   timeout       out  watchdog expired while waiting for the game
//
// All outputs are registered. They are decoded from the next state, so they
// change on the same clock edge as the state register.
// -----------------------------------------------------------------------------
module jogador_automatico #(
    parameter int HOLD_CYCLES    = 5,
    parameter int GAP_CYCLES     = 5,
    parameter int ROUND_WAIT     = 5,
    parameter int NUM_RODADAS    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       comecar,
    input  logic [4:0] erro_rodada,
    input  logic       pronto,
    input  logic       acertou,
    input  logic       errou,
    output logic       iniciar,
    output logic [3:0] chaves,
    output logic [3:0] rodada_atual,
    output logic [3:0] jogada_atual,
    output logic       ocupado,
    output logic       fim_ok,
    output logic       fim_erro,
    output logic       timeout
);

    typedef enum logic [2:0] {
        OCIOSO,
        INICIA,
        ESPERA_RODADA,
        PRESSIONA,
        SOLTA,
        AGUARDA_FIM,
        FIM
    } estado_t;

    localparam int         CNT_W         = 16;
    localparam logic [3:0] ULTIMA_RODADA = 4'(NUM_RODADAS - 1);

    localparam logic [3:0] ROM [16] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
    };

    function automatic logic [3:0] rom_jogada(input logic [3:0] idx);
        return ROM[idx];
    endfunction

    // A one-hot value rotated by one position is always a different key.
    function automatic logic [3:0] rotaciona(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rodada_q, rodada_d;
    logic [3:0]       jogada_q, jogada_d;
    logic [4:0]       erro_q, erro_d;
    logic             fim_ok_q, fim_ok_d;
    logic             fim_erro_q, fim_erro_d;
    logic             timeout_q, timeout_d;
    logic             iniciar_q, iniciar_d;
    logic             ocupado_q, ocupado_d;
    logic [3:0]       chaves_q, chaves_d;
    logic             monitorando;
    logic             injeta;

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q + CNT_W'(1);
        rodada_d   = rodada_q;
        jogada_d   = jogada_q;
        erro_d     = erro_q;
        fim_ok_d   = fim_ok_q;
        fim_erro_d = fim_erro_q;
        timeout_d  = timeout_q;

        monitorando = (estado_q == ESPERA_RODADA) || (estado_q == PRESSIONA) ||
                      (estado_q == SOLTA)         || (estado_q == AGUARDA_FIM);

        case (estado_q)
            OCIOSO: begin
                rodada_d   = 4'd0;
                jogada_d   = 4'd0;
                fim_ok_d   = 1'b0;
                fim_erro_d = 1'b0;
                timeout_d  = 1'b0;
                if (comecar) begin
                    erro_d   = erro_rodada;
                    estado_d = INICIA;
                end
            end

            INICIA: begin
                estado_d = ESPERA_RODADA;
            end

            ESPERA_RODADA: begin
                if (cnt_q == CNT_W'(ROUND_WAIT - 1)) begin
                    jogada_d = 4'd0;
                    estado_d = PRESSIONA;
                end
            end

            PRESSIONA: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    estado_d = SOLTA;
                end
            end

            SOLTA: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    if (jogada_q < rodada_q) begin
                        jogada_d = jogada_q + 4'd1;
                        estado_d = PRESSIONA;
                    end else if (rodada_q < ULTIMA_RODADA) begin
                        rodada_d = rodada_q + 4'd1;
                        estado_d = ESPERA_RODADA;
                    end else begin
                        estado_d = AGUARDA_FIM;
                    end
                end
            end

            AGUARDA_FIM: begin
                if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fim_erro_d = 1'b1;
                    timeout_d  = 1'b1;
                    estado_d   = FIM;
                end
            end

            FIM: begin
                if (comecar) begin
                    erro_d     = erro_rodada;
                    rodada_d   = 4'd0;
                    jogada_d   = 4'd0;
                    fim_ok_d   = 1'b0;
                    fim_erro_d = 1'b0;
                    timeout_d  = 1'b0;
                    estado_d   = INICIA;
                end
`ifdef JOGADOR_REINICIO_EN
                // Replay with the erro_rodada latched for the previous game.
                else if (cnt_q == CNT_W'(ROUND_WAIT - 1)) begin
                    rodada_d   = 4'd0;
                    jogada_d   = 4'd0;
                    fim_ok_d   = 1'b0;
                    fim_erro_d = 1'b0;
                    timeout_d  = 1'b0;
                    estado_d   = INICIA;
                end
`endif
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase

        // The game's verdict overrides any sequencing decision made above,
        // so a key being held is dropped on the very next edge. errou wins
        // over pronto.
        if (monitorando) begin
            if (errou) begin
                fim_ok_d   = 1'b0;
                fim_erro_d = 1'b1;
                timeout_d  = 1'b0;
                estado_d   = FIM;
            end else if (pronto) begin
                fim_ok_d   = acertou;
                fim_erro_d = ~acertou;
                timeout_d  = 1'b0;
                estado_d   = FIM;
            end
        end

        if (estado_d != estado_q) begin
            cnt_d = '0;
        end

        // Inject only on the last jogada of the selected round. A latched
        // value above the round count never matches, because rodada+1 <= 16.
        injeta = (erro_q == ({1'b0, rodada_d} + 5'd1)) && (jogada_d == rodada_d);

        iniciar_d = (estado_d == INICIA);
        ocupado_d = (estado_d != OCIOSO) && (estado_d != FIM);
        chaves_d  = 4'd0;
        if (estado_d == PRESSIONA) begin
            chaves_d = injeta ? rotaciona(rom_jogada(jogada_d)) : rom_jogada(jogada_d);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            cnt_q      <= '0;
            rodada_q   <= 4'd0;
            jogada_q   <= 4'd0;
            erro_q     <= 5'd0;
            fim_ok_q   <= 1'b0;
            fim_erro_q <= 1'b0;
            timeout_q  <= 1'b0;
            iniciar_q  <= 1'b0;
            ocupado_q  <= 1'b0;
            chaves_q   <= 4'd0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            rodada_q   <= rodada_d;
            jogada_q   <= jogada_d;
            erro_q     <= erro_d;
            fim_ok_q   <= fim_ok_d;
            fim_erro_q <= fim_erro_d;
            timeout_q  <= timeout_d;
            iniciar_q  <= iniciar_d;
            ocupado_q  <= ocupado_d;
            chaves_q   <= chaves_d;
        end
    end

    assign iniciar      = iniciar_q;
    assign chaves       = chaves_q;
    assign rodada_atual = rodada_q;
    assign jogada_atual = jogada_q;
    assign ocupado      = ocupado_q;
    assign fim_ok       = fim_ok_q;
    assign fim_erro     = fim_erro_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// -----------------------------------------------------------------------------
// Testbench for jogador_automatico (NUM_RODADAS = 4). It runs a table of whole
// games against a small model of circuito_exp5. It then runs hand-written
// sequences for reset, busy comecar and the FIM exits.
// -----------------------------------------------------------------------------
module tb_jogador_automatico;

    localparam int NR    = 4;
    localparam int TOTAL = NR * (NR + 1) / 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       comecar = 1'b0;
    logic [4:0] erro_rodada = 5'd0;
    logic       pronto = 1'b0;
    logic       acertou = 1'b0;
    logic       errou = 1'b0;
    logic       iniciar;
    logic [3:0] chaves;
    logic [3:0] rodada_atual;
    logic [3:0] jogada_atual;
    logic       ocupado;
    logic       fim_ok;
    logic       fim_erro;
    logic       timeout;

    jogador_automatico #(.NUM_RODADAS(NR)) dut (
        .clock        (clock),
        .reset        (reset),
        .comecar      (comecar),
        .erro_rodada  (erro_rodada),
        .pronto       (pronto),
        .acertou      (acertou),
        .errou        (errou),
        .iniciar      (iniciar),
        .chaves       (chaves),
        .rodada_atual (rodada_atual),
        .jogada_atual (jogada_atual),
        .ocupado      (ocupado),
        .fim_ok       (fim_ok),
        .fim_erro     (fim_erro),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    logic [3:0] rom_tb [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                                4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

    int nvec = 0;
    int nfail = 0;

    // Monitor and game-model state. It is updated only by tick().
    int         cyc = 0;
    int         npress, first_lat, ini_cnt, ini_cyc, last_rel;
    logic [3:0] pv [64];
    int         pstart [64];
    int         holds [64];
    int         gaps [64];
    logic [3:0] prev = 4'd0;
    int         game_mode;   // 0 honest, 1 silent, 2 reports a loss via pronto
    int         gj, gr, gnp;

    typedef struct {
        logic [4:0] erro;
        int         mode;
        logic       exp_ok;
        logic       exp_erro;
        logic       exp_to;
        int         exp_presses;
        logic [3:0] exp_wrong;    // injected key on the last press, 0 = none
        int         exp_last_hold;
        int         exp_fim_lat;  // cycles from last release to FIM, -1 = skip
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock cycle: the DUT outputs are observed at the falling edge. The
    // game model reacts there, then #1 leaves time for the main flow.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (iniciar) begin
            ini_cnt++;
            ini_cyc = cyc;
        end
        if (chaves != 4'd0 && prev == 4'd0) begin
            if (npress < 64) begin
                pv[npress]     = chaves;
                pstart[npress] = cyc;
                gaps[npress]   = (npress == 0) ? 0 : cyc - last_rel;
            end
            if (npress == 0) first_lat = cyc - ini_cyc;
            npress++;
            if (game_mode != 1) begin
                if (chaves != rom_tb[gj]) errou = 1'b1;
                gnp++;
                gj++;
                if (gj > gr) begin
                    gr++;
                    gj = 0;
                end
            end
        end else if (chaves == 4'd0 && prev != 4'd0) begin
            if (npress > 0 && npress <= 64) holds[npress-1] = cyc - pstart[npress-1];
            last_rel = cyc;
            if (game_mode != 1 && gnp == TOTAL && !errou) begin
                pronto  = 1'b1;
                acertou = (game_mode == 0);
            end
        end
        prev = chaves;
        #1;
    endtask

    task automatic clear_mon();
        npress = 0; first_lat = 0; ini_cnt = 0; ini_cyc = 0; last_rel = 0;
        gj = 0; gr = 0; gnp = 0;
        prev = chaves;
        pronto = 1'b0; acertou = 1'b0; errou = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_game(input logic [4:0] er, input int mode);
        clear_mon();
        game_mode   = mode;
        erro_rodada = er;
        comecar     = 1'b1;
        tick();
        comecar     = 1'b0;
    endtask

    task automatic wait_fim(output bit done);
        done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (!ocupado) begin
                done = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        bit         done;
        int         r, j, bad_v, bad_h, bad_g;
        logic [3:0] expv;
        int         fcyc;

        //              erro   mode ok erro to  presses wrong hold lat
        vecs[0] = '{5'd0,  0, 1'b1, 1'b0, 1'b0, 10, 4'd0, 5,  1};
        vecs[1] = '{5'd4,  0, 1'b0, 1'b1, 1'b0, 10, 4'd1, 1, -1};
        vecs[2] = '{5'd0,  1, 1'b0, 1'b1, 1'b1, 10, 4'd0, 5, 69};
        vecs[3] = '{5'd1,  0, 1'b0, 1'b1, 1'b0,  1, 4'd2, 1, -1};
        vecs[4] = '{5'd2,  0, 1'b0, 1'b1, 1'b0,  3, 4'd4, 1, -1};
        vecs[5] = '{5'd5,  0, 1'b1, 1'b0, 1'b0, 10, 4'd0, 5,  1};
        vecs[6] = '{5'd31, 0, 1'b1, 1'b0, 1'b0, 10, 4'd0, 5,  1};
        vecs[7] = '{5'd0,  2, 1'b0, 1'b1, 1'b0, 10, 4'd0, 5,  1};

        game_mode = 0;
        clear_mon();

        // Reset state, both while reset is held and after release.
        repeat (10) tick();
        chk("reset_outputs", {iniciar, chaves, rodada_atual, jogada_atual,
                              ocupado, fim_ok, fim_erro, timeout}, 0);
        reset = 1'b0;
        repeat (3) tick();
        chk("idle_outputs", {iniciar, chaves, rodada_atual, jogada_atual,
                             ocupado, fim_ok, fim_erro, timeout}, 0);

        // Whole games from the table.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            start_game(vecs[i].erro, vecs[i].mode);
            wait_fim(done);
            chk($sformatf("v%0d_reached_fim", i), done, 1);
            chk($sformatf("v%0d_flags", i), {fim_ok, fim_erro, timeout},
                {vecs[i].exp_ok, vecs[i].exp_erro, vecs[i].exp_to});
            chk($sformatf("v%0d_chaves_idle", i), chaves, 0);
            chk($sformatf("v%0d_iniciar_pulses", i), ini_cnt, 1);
            chk($sformatf("v%0d_presses", i), npress, vecs[i].exp_presses);
            chk($sformatf("v%0d_first_latency", i), first_lat, 6);
            bad_v = 0; bad_h = 0; bad_g = 0;
            r = 0; j = 0;
            for (int p = 0; p < npress && p < 64; p++) begin
                expv = rom_tb[j];
                if (p == vecs[i].exp_presses - 1 && vecs[i].exp_wrong != 4'd0)
                    expv = vecs[i].exp_wrong;
                if (pv[p] != expv) bad_v++;
                if (p == npress - 1) begin
                    if (holds[p] != vecs[i].exp_last_hold) bad_h++;
                end else if (holds[p] != 5) begin
                    bad_h++;
                end
                if (p > 0 && gaps[p] != ((j == 0) ? 10 : 5)) bad_g++;
                j++;
                if (j > r) begin
                    r++;
                    j = 0;
                end
            end
            chk($sformatf("v%0d_press_values", i), bad_v, 0);
            chk($sformatf("v%0d_hold_lengths", i), bad_h, 0);
            chk($sformatf("v%0d_gap_lengths", i), bad_g, 0);
            if (vecs[i].exp_fim_lat >= 0)
                chk($sformatf("v%0d_fim_latency", i), cyc - last_rel, vecs[i].exp_fim_lat);
        end

        // Reset asserted during a press of round 2 clears outputs before any edge.
        do_reset();
        start_game(5'd0, 0);
        done = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (rodada_atual == 4'd1 && chaves != 4'd0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("midhold_reached", done, 1);
        #1 reset = 1'b1;
        #1;
        chk("midhold_async_clear", {chaves, ocupado, rodada_atual, iniciar}, 0);
        tick();
        reset = 1'b0;
        clear_mon();
        repeat (10) tick();
        chk("midhold_stays_idle", {chaves, ocupado, iniciar}, 0);

        // comecar during round 3 (with a new erro_rodada) is ignored.
        do_reset();
        start_game(5'd0, 0);
        done = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (rodada_atual == 4'd2) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("busy_reached_round3", done, 1);
        erro_rodada = 5'd3;
        comecar = 1'b1;
        tick();
        comecar = 1'b0;
        erro_rodada = 5'd0;
        wait_fim(done);
        chk("busy_reached_fim", done, 1);
        chk("busy_iniciar_pulses", ini_cnt, 1);
        chk("busy_presses", npress, TOTAL);
        chk("busy_flags", {fim_ok, fim_erro, timeout}, 3'b100);
        fcyc = cyc;

`ifdef JOGADOR_REINICIO_EN
        // FIM restarts on its own and replays round 1.
        clear_mon();
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (ini_cnt > 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("restart_iniciar_seen", done, 1);
        chk("restart_delay", ini_cyc - fcyc, 5);
        chk("restart_flags_cleared", {fim_ok, fim_erro, timeout}, 0);
        for (int k = 0; k < 20 && npress == 0; k++) tick();
        chk("restart_first_key", pv[0], 1);
        chk("restart_first_latency", first_lat, 6);
`else
        // FIM holds its flags, then a comecar starts a new game with flags cleared.
        repeat (3) tick();
        chk("fim_hold_flags", {fim_ok, fim_erro, timeout, ocupado}, 4'b1000);
        chk("fim_no_restart", ini_cnt, 1);
        clear_mon();
        erro_rodada = 5'd0;
        comecar = 1'b1;
        tick();
        comecar = 1'b0;
        chk("fim_comecar_iniciar", {iniciar, ocupado}, 2'b11);
        chk("fim_comecar_flags", {fim_ok, fim_erro, timeout}, 0);
        tick();
        chk("fim_comecar_single_pulse", iniciar, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
